uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, giving the data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter OVERSAMPLE, default 16, giving Sample_en pulses per bit period (even, >=8).
REQ-003 Port Sys_clock, input, 1 bit, the single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be a synchronous, active-high reset.
REQ-005 Port Sample_en, input, 1 bit, one-Sys_clock-wide tick at OVERSAMPLE x baud, taken from uart_clk_gen Sample_clock after edge conversion.
REQ-006 Port Rx, input, 1 bit, the asynchronous serial line; idle level is 1.
REQ-007 Port Data_out, output, DATA_BITS wide, the last good received word.
REQ-008 Port Data_valid, output, 1 bit, a one-cycle pulse when Data_out is updated.
REQ-009 Port Framing_error, output, 1 bit, a one-cycle pulse when the stop bit samples 0.
REQ-010 Port Busy, output, 1 bit, high in every state except IDLE.

Function
REQ-011 Rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (rx_s).
REQ-012 The tick counter and bit counter SHALL advance only on cycles with Sample_en=1.
REQ-013 The state machine SHALL have states IDLE, START, DATA, STOP and WAIT_HIGH (plus PARITY, see REQ-024).
- IDLE: rx_s=0 on a tick -> START, tick counter cleared.
- START: after OVERSAMPLE/2 ticks, resample rx_s; if 0 -> DATA; if 1 (glitch) -> IDLE with no outputs.
- DATA: sample rx_s every OVERSAMPLE ticks (mid-bit), shifting LSB first; after DATA_BITS samples -> STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s; if 1 -> IDLE; if 0 -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1 on a tick, then -> IDLE. Line-break lockout: no restart while the line is held low.
REQ-014 On a good stop bit, Data_out SHALL load the shift register and Data_valid SHALL pulse on the Sys_clock cycle after the stop-sample tick.
REQ-015 On a bad stop bit, Framing_error SHALL pulse on that same cycle, Data_out SHALL hold and Data_valid SHALL stay 0.
REQ-016 Data_out SHALL hold its value between frames; the block has no consumer handshake and a new frame overwrites the old one.
REQ-017 Counters SHALL wrap only by explicit clear on a state change; the bit counter SHALL be $clog2(DATA_BITS+1) bits wide.
REQ-018 A start edge in the same cycle as a stop-bit completion SHALL be ignored; detection SHALL begin from IDLE on the next tick.

Reset
REQ-019 While reset=1 the state SHALL be IDLE, counters and the shift register SHALL be 0, and the synchronizer flops SHALL be 1.
REQ-020 Reset values: Data_out=0, Data_valid=0, Framing_error=0, Busy=0 (Parity_error=0 when compiled in).
REQ-021 Reset SHALL override Sample_en and take effect mid-frame, with no partial-word output.

Configuration
REQ-022 Macro UART_RX_PARITY_EN SHALL control parity support.
REQ-023 Without the macro, frames SHALL be start + DATA_BITS + stop, and there SHALL be no Parity_error port.
REQ-024 With the macro, the block SHALL add state PARITY between DATA and STOP, sample one even-parity bit, and add output port Parity_error (1 bit).
REQ-025 With the macro and a parity mismatch plus a good stop bit, Parity_error SHALL pulse in place of Data_valid and Data_out SHALL hold.

Structure
REQ-026 Shared package uart_pkg SHALL hold the rx_state_t enum, the IDLE_LEVEL constant and the default OVERSAMPLE; uart_clk_gen SHALL be able to share it.
REQ-027 Sub-module uart_sync2 (the 2-flop synchronizer with reset value 1) SHALL be instantiated once.

Verification
All scenarios run at 8 MHz Sys_clock with Sample_en every 52 cycles (9600 baud x16).
REQ-028 Frame 0xA5 with a good stop bit -> Data_out=8'hA5 and exactly one Data_valid pulse; Framing_error stays 0.
REQ-029 Rx low for 4 ticks, then high -> no Data_valid and no Framing_error; Busy falls back to 0 within 9 ticks.
REQ-030 Frame 0x3C with stop=0 and the line held low for 40 ticks -> one Framing_error pulse, Data_out unchanged, Busy=1 until the line returns high.
REQ-031 reset pulsed during bit 3 of 0xFF -> outputs 0 and IDLE on the next cycle; the following frame 0x5A -> Data_out=8'h5A.
REQ-032 Back-to-back frames 0x00 then 0xFF with a one-bit stop -> two Data_valid pulses, Data_out ending at 8'hFF.
REQ-033 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> one Parity_error pulse and no Data_valid; with parity bit 1 -> Data_valid and Data_out=8'h07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and default oversampling.
// Used by uart_rx and uart_sync2 and shareable with uart_clk_gen.
package uart_pkg;

   localparam logic        IDLE_LEVEL         = 1'b1;
   localparam int unsigned DEFAULT_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StWaitHigh
   } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; both flops reset to the idle level.
module uart_sync2
   import uart_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= IDLE_LEVEL;
         sync_q <= IDLE_LEVEL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit glitch rejection, mid-bit sampling, line-break lockout.
// Define UART_RX_PARITY_EN to add an even-parity bit and the Parity_error output.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
   input  logic                 Sys_clock,
   input  logic                 reset,
   input  logic                 Sample_en,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] Data_out,
   output logic                 Data_valid,
   output logic                 Framing_error,
`ifdef UART_RX_PARITY_EN
   output logic                 Parity_error,
`endif
   output logic                 Busy
);

   localparam int unsigned TickW = $clog2(OVERSAMPLE);
   localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

   localparam logic [TickW-1:0] HalfLast = TickW'(OVERSAMPLE / 2 - 1);
   localparam logic [TickW-1:0] FullLast = TickW'(OVERSAMPLE - 1);
   localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
   localparam rx_state_t AfterData = StParity;
`else
   localparam rx_state_t AfterData = StStop;
`endif

   rx_state_t            state_q;
   logic [TickW-1:0]     tick_q;
   logic [BitW-1:0]      bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 ferr_q;
   logic                 busy_q;
   logic                 rx_s;
`ifdef UART_RX_PARITY_EN
   logic                 perr_q;
   logic                 par_bad_q;
`endif

   uart_sync2 u_sync (
      .clk_i (Sys_clock),
      .rst_i (reset),
      .d_i   (Rx),
      .q_o   (rx_s)
   );

   always_ff @(posedge Sys_clock) begin
      if (reset) begin
         state_q   <= StIdle;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
         par_bad_q <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q  <= 1'b0;
`endif
         if (Sample_en) begin
            unique case (state_q)
               StIdle: begin
                  if (rx_s != IDLE_LEVEL) begin
                     state_q <= StStart;
                     busy_q  <= 1'b1;
                     tick_q  <= '0;
                  end
               end
               StStart: begin
                  if (tick_q == HalfLast) begin
                     tick_q <= '0;
                     // A start bit that is gone by mid-bit was a glitch.
                     if (rx_s == IDLE_LEVEL) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                     end else begin
                        state_q <= StData;
                        bit_q   <= '0;
                     end
                  end else begin
                     tick_q <= tick_q + TickW'(1);
                  end
               end
               StData: begin
                  if (tick_q == FullLast) begin
                     tick_q  <= '0;
                     shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                     if (bit_q == BitLast) begin
                        bit_q   <= '0;
                        state_q <= AfterData;
                     end else begin
                        bit_q <= bit_q + BitW'(1);
                     end
                  end else begin
                     tick_q <= tick_q + TickW'(1);
                  end
               end
`ifdef UART_RX_PARITY_EN
               StParity: begin
                  if (tick_q == FullLast) begin
                     tick_q    <= '0;
                     par_bad_q <= rx_s ^ (^shift_q);
                     state_q   <= StStop;
                  end else begin
                     tick_q <= tick_q + TickW'(1);
                  end
               end
`endif
               StStop: begin
                  if (tick_q == FullLast) begin
                     tick_q <= '0;
                     if (rx_s == IDLE_LEVEL) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        if (par_bad_q) begin
                           perr_q <= 1'b1;
                        end else begin
                           data_q  <= shift_q;
                           valid_q <= 1'b1;
                        end
`else
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
`endif
                     end else begin
                        // Hold off restart until the line break ends.
                        state_q <= StWaitHigh;
                        ferr_q  <= 1'b1;
                     end
                  end else begin
                     tick_q <= tick_q + TickW'(1);
                  end
               end
               StWaitHigh: begin
                  if (rx_s == IDLE_LEVEL) begin
                     state_q <= StIdle;
                     busy_q  <= 1'b0;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Data_out      = data_q;
   assign Data_valid    = valid_q;
   assign Framing_error = ferr_q;
   assign Busy          = busy_q;
`ifdef UART_RX_PARITY_EN
   assign Parity_error  = perr_q;
`endif

endmodule
